// File: rtl/capture_rle_ctrl.sv
// capture_rle_ctrl: logic-analyser capture controller with circular
// pre-trigger region, RLE post-trigger fill and a bookkeeping line.
module capture_rle_ctrl #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = 6,
    parameter int PRE_LINES = 4
) (
    input  logic                      clk_of_verifla,
    input  logic                      rst_l,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [DATA_W-1:0]         trig_mask,
    input  logic [DATA_W-1:0]         trig_value,
    input  logic                      trig_edge,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [CNT_W+DATA_W-1:0]   rd_data,
    output logic                      busy,
    output logic                      triggered,
    output logic                      done
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LINE_W = CNT_W + DATA_W;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_LINES - 1);
    localparam logic [ADDR_W-1:0] TRIG_LINE = ADDR_W'(PRE_LINES);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] BOOK_LINE = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_POST,
        S_FINAL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pre_ptr_q, pre_ptr_d;
    logic [ADDR_W-1:0]   post_ptr_q, post_ptr_d;
    logic [ADDR_W-1:0]   last_pre_q, last_pre_d;
    logic                pre_wrapped_q, pre_wrapped_d;
    logic                pre_empty_q, pre_empty_d;
    logic                prev_match_q, prev_match_d;
    logic [DATA_W-1:0]   last_data_q, last_data_d;
    logic [CNT_W-1:0]    last_cnt_q, last_cnt_d;
    logic                busy_q, busy_d;
    logic                triggered_q, triggered_d;
    logic                done_q, done_d;
    logic [LINE_W-1:0]   rd_data_q;

    logic [LINE_W-1:0]   mem [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [LINE_W-1:0]   wr_data;
    logic                match;
    logic                fire;
    logic [ADDR_W-1:0]   post_nxt;
    logic [DATA_W-1:0]   book;

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign triggered = triggered_q;
    assign done      = done_q;

    // Trigger qualification: mask/value compare, optionally edge-gated
    always_comb begin
        match    = ((data_in ^ trig_value) & trig_mask) == '0;
        fire     = trig_edge ? (match && !prev_match_q) : match;
        post_nxt = post_ptr_q + ADDR_W'(1);
        book     = '0;
        book[ADDR_W+1:0] = {pre_empty_q, pre_wrapped_q, last_pre_q};
    end

    // Next-state, bookkeeping and RAM write-port control
    always_comb begin
        state_d       = state_q;
        pre_ptr_d     = pre_ptr_q;
        post_ptr_d    = post_ptr_q;
        last_pre_d    = last_pre_q;
        pre_wrapped_d = pre_wrapped_q;
        pre_empty_d   = pre_empty_q;
        prev_match_d  = prev_match_q;
        last_data_d   = last_data_q;
        last_cnt_d    = last_cnt_q;
        busy_d        = busy_q;
        triggered_d   = triggered_q;
        done_d        = done_q;
        we            = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d       = S_PRE;
                    busy_d        = 1'b1;
                    triggered_d   = 1'b0;
                    done_d        = 1'b0;
                    pre_ptr_d     = '0;
                    post_ptr_d    = '0;
                    last_pre_d    = '0;
                    pre_wrapped_d = 1'b0;
                    pre_empty_d   = 1'b1;
                    // Seed with the bus state at arm so an already
                    // matching bus cannot produce an edge trigger.
                    prev_match_d  = match;
                end
            end
            S_PRE: begin
                prev_match_d = match;
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (fire) begin
                    we          = 1'b1;
                    wr_addr     = TRIG_LINE;
                    wr_data     = {CNT_ONE, data_in};
                    post_ptr_d  = TRIG_LINE;
                    last_data_d = data_in;
                    last_cnt_d  = CNT_ONE;
                    triggered_d = 1'b1;
                    state_d     = S_POST;
                end else begin
                    we          = 1'b1;
                    wr_addr     = pre_ptr_q;
                    wr_data     = {CNT_ONE, data_in};
                    last_pre_d  = pre_ptr_q;
                    pre_empty_d = 1'b0;
                    if (pre_ptr_q == PRE_LAST) begin
                        pre_ptr_d     = '0;
                        pre_wrapped_d = 1'b1;
                    end else begin
                        pre_ptr_d = pre_ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_POST: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (data_in == last_data_q &&
                             last_cnt_q != CNT_MAX) begin
                    we         = 1'b1;
                    wr_addr    = post_ptr_q;
                    wr_data    = {last_cnt_q + CNT_ONE, data_in};
                    last_cnt_d = last_cnt_q + CNT_ONE;
                end else begin
                    we          = 1'b1;
                    wr_addr     = post_nxt;
                    wr_data     = {CNT_ONE, data_in};
                    post_ptr_d  = post_nxt;
                    last_data_d = data_in;
                    last_cnt_d  = CNT_ONE;
                    if (post_nxt == POST_LAST) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                we      = 1'b1;
                wr_addr = BOOK_LINE;
                wr_data = {{CNT_W{1'b0}}, book};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk_of_verifla or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= S_IDLE;
            pre_ptr_q     <= '0;
            post_ptr_q    <= '0;
            last_pre_q    <= '0;
            pre_wrapped_q <= 1'b0;
            pre_empty_q   <= 1'b1;
            prev_match_q  <= 1'b0;
            last_data_q   <= '0;
            last_cnt_q    <= '0;
            busy_q        <= 1'b0;
            triggered_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_ptr_q     <= pre_ptr_d;
            post_ptr_q    <= post_ptr_d;
            last_pre_q    <= last_pre_d;
            pre_wrapped_q <= pre_wrapped_d;
            pre_empty_q   <= pre_empty_d;
            prev_match_q  <= prev_match_d;
            last_data_q   <= last_data_d;
            last_cnt_q    <= last_cnt_d;
            busy_q        <= busy_d;
            triggered_q   <= triggered_d;
            done_q        <= done_d;
        end
    end

    // Capture RAM write port; contents survive reset
    always_ff @(posedge clk_of_verifla) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read-first readout port
    always_ff @(posedge clk_of_verifla or negedge rst_l) begin
        if (!rst_l) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_capture_rle_ctrl.sv
// tb_capture_rle_ctrl: directed-vector bench for capture_rle_ctrl
// using immediate assertions at every comparison point.
module tb_capture_rle_ctrl;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] data_in;
    logic        arm;
    logic        abort;
    logic [15:0] trig_mask;
    logic [15:0] trig_value;
    logic        trig_edge;
    logic [5:0]  rd_addr;
    logic [23:0] rd_data;
    logic        busy;
    logic        triggered;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    capture_rle_ctrl dut (
        .clk_of_verifla (clk),
        .rst_l          (rst_l),
        .data_in        (data_in),
        .arm            (arm),
        .abort          (abort),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .trig_edge      (trig_edge),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .triggered      (triggered),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic b,
                          input logic t, input logic d);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".trig"}, 32'(triggered), 32'(t));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic rd(input string tag, input logic [5:0] a,
                      input logic [23:0] e);
        rd_addr = a;
        tick();
        check(tag, 32'(rd_data), 32'(e));
    endtask

    initial begin
        rst_l      = 1'b0;
        data_in    = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_mask  = 16'hFFFF;
        trig_value = 16'h0006;
        trig_edge  = 1'b0;
        rd_addr    = '0;
        #1;
        status("reset", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset.rd_data", 32'(rd_data), 32'h0);
        rst_l = 1'b1;
        tick();

        // Basic capture: counting bus, level trigger on 6
        arm = 1'b1;
        tick();
        arm = 1'b0;
        status("basic.armed", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            data_in = 16'(i);
            tick();
        end
        status("basic.pre", 1'b1, 1'b0, 1'b0);
        data_in = 16'h0006;
        tick();
        status("basic.trig", 1'b1, 1'b1, 1'b0);
        for (int i = 7; i <= 64; i++) begin
            data_in = 16'(i);
            tick();
        end
        status("basic.last", 1'b1, 1'b1, 1'b0);
        data_in = 16'h0041;
        tick();
        status("basic.done", 1'b0, 1'b1, 1'b1);
        rd("basic.l0", 6'd0, 24'h010004);
        rd("basic.l1", 6'd1, 24'h010005);
        rd("basic.l2", 6'd2, 24'h010002);
        rd("basic.l3", 6'd3, 24'h010003);
        for (int i = 4; i <= 62; i++) begin
            rd("basic.post", 6'(i), {8'h01, 16'(i + 2)});
        end
        rd("basic.book", 6'd63, 24'h000041);

        // RLE saturation: 300 repeats of AAAA after trigger
        trig_value = 16'h1234;
        data_in    = 16'h1111;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        status("rle.armed", 1'b1, 1'b0, 1'b0);
        tick();
        data_in = 16'h1112;
        tick();
        data_in = 16'h1234;
        tick();
        status("rle.trig", 1'b1, 1'b1, 1'b0);
        data_in = 16'hAAAA;
        repeat (300) tick();
        for (int i = 0; i < 56; i++) begin
            data_in = 16'(i);
            tick();
        end
        status("rle.last", 1'b1, 1'b1, 1'b0);
        tick();
        status("rle.done", 1'b0, 1'b1, 1'b1);
        rd("rle.l0", 6'd0, 24'h011111);
        rd("rle.l1", 6'd1, 24'h011112);
        rd("rle.stale2", 6'd2, 24'h010002);
        rd("rle.l4", 6'd4, 24'h011234);
        rd("rle.l5", 6'd5, 24'hFFAAAA);
        rd("rle.l6", 6'd6, 24'h2DAAAA);
        rd("rle.l7", 6'd7, 24'h010000);
        rd("rle.l62", 6'd62, 24'h010037);
        rd("rle.book", 6'd63, 24'h000001);

        // Edge mode: bus matching at arm must not trigger
        trig_value = 16'h0006;
        trig_edge  = 1'b1;
        data_in    = 16'h0006;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        repeat (3) tick();
        status("edge.hold", 1'b1, 1'b0, 1'b0);
        data_in = 16'h0007;
        tick();
        status("edge.leave", 1'b1, 1'b0, 1'b0);
        data_in = 16'h0006;
        tick();
        status("edge.fire", 1'b1, 1'b1, 1'b0);
        data_in = 16'h0008;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("edge.abort.busy", 32'(busy), 32'h0);
        check("edge.abort.done", 32'(done), 32'h0);
        rd("edge.l0", 6'd0, 24'h010006);
        rd("edge.l3", 6'd3, 24'h010007);
        rd("edge.l4", 6'd4, 24'h010006);
        rd("edge.l5", 6'd5, 24'hFFAAAA);

        // arm and abort together while idle
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("armabort.busy", 32'(busy), 32'h0);

        // Abort in PRE, then re-arm restarts at line 0
        trig_edge  = 1'b0;
        trig_value = 16'h00C3;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 16'h5550 + 16'(i);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        status("abort.pre", 1'b0, 1'b0, 1'b0);
        arm = 1'b1;
        tick();
        arm     = 1'b0;
        data_in = 16'h7777;
        tick();
        data_in = 16'h00C3;
        tick();
        status("restart.trig", 1'b1, 1'b1, 1'b0);
        data_in = 16'h9999;
        tick();

        // Asynchronous reset mid-POST
        rst_l = 1'b0;
        #1;
        status("areset", 1'b0, 1'b0, 1'b0);
        data_in = 16'h4444;
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        status("areset.rel", 1'b0, 1'b0, 1'b0);
        rd("restart.l0", 6'd0, 24'h017777);
        rd("restart.l1", 6'd1, 24'h015551);
        rd("restart.l4", 6'd4, 24'h0100C3);
        rd("restart.l5", 6'd5, 24'h019999);
        rd("areset.l6", 6'd6, 24'h2DAAAA);

        // Empty pre region: trigger on first sample
        arm = 1'b1;
        tick();
        arm     = 1'b0;
        data_in = 16'h00C3;
        tick();
        status("empty.trig", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 58; i++) begin
            data_in = 16'h0100 + 16'(i);
            tick();
        end
        tick();
        status("empty.done", 1'b0, 1'b1, 1'b1);
        rd("empty.l4", 6'd4, 24'h0100C3);
        rd("empty.l5", 6'd5, 24'h010100);
        rd("empty.l62", 6'd62, 24'h010139);
        rd("empty.book", 6'd63, 24'h000080);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
